ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 112 +++++++++++
 tb/tb_ifetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED/FAULT control.
// Define IFETCH_BOUNDS_EN to fault on fetches beyond the instruction memory instead of aliasing.
module ifetch #(
  parameter int unsigned    n         = 32,
  parameter int unsigned    r         = 6,
  parameter logic [n-1:0]   RESET_PC  = '0,
  parameter logic [n-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic [r-1:0] imem_addr,
  input  logic [n-1:0] imem_instr,
  output logic [n-1:0] pc_out,
  output logic [n-1:0] pc_plus4_out,
  output logic [n-1:0] instr_out,
  output logic         valid_out,
  output logic         halted,
  output logic         fault
);

  typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

  state_e       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pc_out_q, pc_out_d;
  logic [n-1:0] pc_plus4_q, pc_plus4_d;
  logic [n-1:0] instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [n-1:0] pc_inc;

  assign pc_inc    = pc_q + n'(4);
  // Low two bits select a byte within the word and play no part in addressing.
  assign imem_addr = pc_q[r+1:2];

`ifdef IFETCH_BOUNDS_EN
  logic out_of_range;
  assign out_of_range = (pc_q >> (r + 2)) != '0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (redirect) begin
      // Flush wins over stall; the word currently on imem_instr is dropped.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (!stall) begin
      case (state_q)
        StRun: begin
`ifdef IFETCH_BOUNDS_EN
          if (out_of_range) begin
            valid_d = 1'b0;
            state_d = StFault;
          end else
`endif
          begin
            pc_out_d   = pc_q;
            pc_plus4_d = pc_inc;
            instr_d    = imem_instr;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
            if (imem_instr == HALT_WORD) state_d = StHalted;
          end
        end
        StHalted: valid_d = 1'b0;
        StFault:  valid_d = 1'b0;
        default: begin
          valid_d = 1'b0;
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_out       = pc_out_q;
  assign pc_plus4_out = pc_plus4_q;
  assign instr_out    = instr_q;
  assign valid_out    = valid_q;
  assign halted       = (state_q == StHalted);
`ifdef IFETCH_BOUNDS_EN
  assign fault        = (state_q == StFault);
`else
  assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: expected IF/ID contents are queued with each step and
// checked one cycle later against a behavioural instruction memory.
module tb_ifetch;
  localparam int unsigned N    = 32;
  localparam int unsigned R    = 6;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset, stall, redirect;
  logic [N-1:0]  redirect_pc, imem_instr, pc_out, pc_plus4_out, instr_out;
  logic [R-1:0]  imem_addr;
  logic          valid_out, halted, fault;
  logic [31:0]   mem [64];

  typedef struct packed {
    logic        v;
    logic        hlt;
    logic        flt;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ifetch #(.n(N), .r(R), .RESET_PC(32'h0), .HALT_WORD(HALT)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .valid_out    (valid_out),
    .halted       (halted),
    .fault        (fault)
  );

  assign imem_instr = mem[imem_addr];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rd, input logic [31:0] rpc);
    reset = rst; stall = stl; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic hlt, input logic flt);
    exp_t e;
    e.v = v; e.pc = pc; e.instr = instr; e.hlt = hlt; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t        e;
    logic [31:0] p4;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e  = sb.pop_front();
      p4 = e.pc + 32'd4;
      check({tag, ".valid"}, 64'(valid_out), 64'(e.v));
      check({tag, ".halted"}, 64'(halted), 64'(e.hlt));
      check({tag, ".fault"}, 64'(fault), 64'(e.flt));
      if (e.v) begin
        check({tag, ".pc"}, 64'(pc_out), 64'(e.pc));
        check({tag, ".pc4"}, 64'(pc_plus4_out), 64'(p4));
        check({tag, ".instr"}, 64'(instr_out), 64'(e.instr));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'(k + 1);

    // Reset values
    drive(1, 0, 0, 32'h0); push(0, 0, 0, 0, 0); tick("reset");
    check("reset.pc_out", 64'(pc_out), 64'd0);
    check("reset.pc4", 64'(pc_plus4_out), 64'd0);
    check("reset.instr", 64'(instr_out), 64'd0);
    check("reset.addr", 64'(imem_addr), 64'd0);

    // Free-running fetch with a 3-cycle stall at pc=8
    drive(0, 0, 0, 32'h0); push(1, 32'd0, 32'd1, 0, 0); tick("run0");
    push(1, 32'd4, 32'd2, 0, 0); tick("run1");
    check("run1.addr", 64'(imem_addr), 64'd2);
    drive(0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      push(1, 32'd4, 32'd2, 0, 0); tick("stall");
      check("stall.addr", 64'(imem_addr), 64'd2);
    end
    drive(0, 0, 0, 32'h0); push(1, 32'd8, 32'd3, 0, 0); tick("resume8");
    push(1, 32'd12, 32'd4, 0, 0); tick("run12");

    // Redirect together with stall: flush wins
    drive(0, 1, 1, 32'h20); push(0, 0, 0, 0, 0); tick("redir_stall");
    check("redir_stall.addr", 64'(imem_addr), 64'd8);
    drive(0, 0, 0, 32'h0); push(1, 32'h20, 32'd9, 0, 0); tick("redir_tgt");

    // Misaligned target: PC keeps low bits, addressing ignores them
    drive(0, 0, 1, 32'h23); push(0, 0, 0, 0, 0); tick("mis_redir");
    check("mis_redir.addr", 64'(imem_addr), 64'd8);
    drive(0, 0, 0, 32'h0); push(1, 32'h23, 32'd9, 0, 0); tick("mis0");
    push(1, 32'h27, 32'd10, 0, 0); tick("mis1");

    // Halt word at word 3
    mem[3] = HALT;
    drive(0, 0, 1, 32'h4); push(0, 0, 0, 0, 0); tick("h_redir");
    drive(0, 0, 0, 32'h0); push(1, 32'd4, 32'd2, 0, 0); tick("h4");
    push(1, 32'd8, 32'd3, 0, 0); tick("h8");
    push(1, 32'd12, HALT, 1, 0); tick("h12");
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 0, 1, 0); tick("halted");
      check("halted.addr", 64'(imem_addr), 64'd4);
    end
    drive(0, 0, 1, 32'h0); push(0, 0, 0, 0, 0); tick("unhalt");
    drive(0, 0, 0, 32'h0); push(1, 32'd0, 32'd1, 0, 0); tick("unhalt0");

    // Running past the end of instruction memory
    drive(0, 0, 1, 32'hF8); push(0, 0, 0, 0, 0); tick("edge_redir");
    drive(0, 0, 0, 32'h0); push(1, 32'hF8, 32'd63, 0, 0); tick("edgeF8");
    push(1, 32'hFC, 32'd64, 0, 0); tick("edgeFC");
`ifdef IFETCH_BOUNDS_EN
    push(0, 0, 0, 0, 1); tick("bounds_fault");
    push(0, 0, 0, 0, 1); tick("fault_hold");
`else
    push(1, 32'h100, 32'd1, 0, 0); tick("alias100");
    check("alias100.addr", 64'(imem_addr), 64'd1);
    // pc+4 wraps modulo 2**32
    drive(0, 0, 1, 32'hFFFF_FFFC); push(0, 0, 0, 0, 0); tick("wrap_redir");
    drive(0, 0, 0, 32'h0); push(1, 32'hFFFF_FFFC, 32'd64, 0, 0); tick("wrap");
    check("wrap.addr", 64'(imem_addr), 64'd0);
`endif

    // Reset in HALTED with redirect and stall asserted
    drive(0, 0, 1, 32'd12); push(0, 0, 0, 0, 0); tick("rh_redir");
    drive(0, 0, 0, 32'h0); push(1, 32'd12, HALT, 1, 0); tick("rh_halt");
    drive(1, 1, 1, 32'h40); push(0, 0, 0, 0, 0); tick("rh_reset");
    check("rh_reset.pc_out", 64'(pc_out), 64'd0);
    check("rh_reset.pc4", 64'(pc_plus4_out), 64'd0);
    check("rh_reset.instr", 64'(instr_out), 64'd0);
    check("rh_reset.addr", 64'(imem_addr), 64'd0);
    drive(0, 0, 0, 32'h0); push(1, 32'd0, 32'd1, 0, 0); tick("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
